// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave: oversampled pins, MSB-first words, truncated-frame flag, response word on MISO.
// Events act SYNC_STAGES+1 clk edges after the pin change; no backpressure, rx_valid/frame_err are 1-cycle pulses.
module spi_slave_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  input  logic              spi_cs,
  output logic              spi_miso,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int LAST  = SYNC_STAGES - 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync, fill;
  logic                   sclk_d, cs_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      fill      <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
      sclk_d    <= sclk_sync[LAST];
      cs_d      <= cs_sync[LAST];
    end
  end

  logic sclk_s, mosi_s, cs_s;
  logic sck_rise, sck_fall, cs_fall, cs_rise;

  assign sclk_s   = sclk_sync[LAST];
  assign mosi_s   = mosi_sync[LAST];
  assign cs_s     = cs_sync[LAST];
  assign sck_rise =  sclk_s & ~sclk_d;
  assign sck_fall = ~sclk_s &  sclk_d;
  assign cs_fall  = ~cs_s   &  cs_d;
  assign cs_rise  =  cs_s   & ~cs_d;

  state_t            state, state_n;
  logic              armed, armed_n;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [DATA_W-2:0] rx_shift, rx_shift_n;
  logic [DATA_W-2:0] tx_shift, tx_shift_n;
  logic [DATA_W-1:0] rx_data_n;
  logic              miso_n, rx_valid_n, frame_err_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      armed     <= 1'b0;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      rx_data   <= '0;
      spi_miso  <= 1'b0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      armed     <= armed_n;
      bit_cnt   <= bit_cnt_n;
      rx_shift  <= rx_shift_n;
      tx_shift  <= tx_shift_n;
      rx_data   <= rx_data_n;
      spi_miso  <= miso_n;
      rx_valid  <= rx_valid_n;
      frame_err <= frame_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    // Synchroniser still holds reset values until fill completes; only trust cs after that.
    armed_n     = armed | (fill[LAST] & cs_s);
    bit_cnt_n   = bit_cnt;
    rx_shift_n  = rx_shift;
    tx_shift_n  = tx_shift;
    rx_data_n   = rx_data;
    miso_n      = spi_miso;
    rx_valid_n  = 1'b0;
    frame_err_n = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall && armed) begin
          state_n    = ACTIVE;
          bit_cnt_n  = '0;
          tx_shift_n = tx_data[DATA_W-2:0];
          miso_n     = tx_data[DATA_W-1];
        end
      end
      ACTIVE: begin
        if (sck_rise) begin
          rx_shift_n = {rx_shift[DATA_W-3+1:0], mosi_s} >> 0;
          if (bit_cnt == CNT_W'(DATA_W - 1)) begin
            rx_data_n  = {rx_shift, mosi_s};
            rx_valid_n = 1'b1;
            bit_cnt_n  = '0;
          end else begin
            bit_cnt_n = bit_cnt + CNT_W'(1);
          end
        end
        if (sck_fall) begin
          if (bit_cnt != '0) begin
            miso_n     = tx_shift[DATA_W-2];
            tx_shift_n = tx_shift << 1;
          end else begin
            miso_n     = tx_data[DATA_W-1];
            tx_shift_n = tx_data[DATA_W-2:0];
          end
        end
        // Uses the post-rise count so a word completing on this cycle is not an error.
        if (cs_rise) begin
          state_n     = IDLE;
          miso_n      = 1'b0;
          frame_err_n = (bit_cnt_n != '0);
          bit_cnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == ACTIVE);

endmodule

// File: tb/tb_spi_slave_rx.sv
// Randomised bench for spi_slave_rx: pin-level SPI master, queue scoreboard for rx events and MISO words.
module tb_spi_slave_rx;

  logic       clk;
  logic       reset_n;
  logic       spi_sclk, spi_mosi, spi_cs;
  logic       spi_miso;
  logic [7:0] tx_data, rx_data;
  logic       rx_valid, frame_err, busy;

  spi_slave_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .spi_cs    (spi_cs),
    .spi_miso  (spi_miso),
    .tx_data   (tx_data),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  typedef struct packed {
    logic        is_err;
    logic [7:0]  dat;
    logic [31:0] cyc;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] exp_miso[$];
  logic [7:0] fw[4];
  logic [7:0] ft[4];
  logic [7:0] last_rx;
  int         cyc;
  int         chk_cnt;
  int         pass_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic take_event(input logic is_err, input logic [7:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk_cnt++;
      $display("FAIL unexpected_event: got err=%0d data %0h, expected no event (cycle %0d)", is_err, d, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", 32'(is_err), 32'(e.is_err));
      if (!is_err) chk("rx_word", 32'(d), 32'(e.dat));
      chk("event_cycle", 32'(cyc), e.cyc);
    end
  endtask

  // Output monitor: rx_valid / frame_err pulses against the event queue.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset_n) begin
        if (rx_valid)  take_event(1'b0, rx_data);
        if (frame_err) take_event(1'b1, 8'h00);
      end
    end
  end

  // MISO monitor: samples on each sclk pin rise like the master does; partial words are dropped.
  initial begin
    logic       prev;
    int         n;
    logic [7:0] w;
    logic [7:0] e;
    prev = 1'b0;
    n    = 0;
    w    = 8'h00;
    forever begin
      @(spi_sclk or spi_cs or reset_n);
      if (!reset_n) begin
        n = 0;
      end else begin
        if (spi_sclk && !prev) begin
          w = {w[6:0], spi_miso};
          n++;
          if (n == 8) begin
            n = 0;
            if (exp_miso.size() == 0) begin
              chk_cnt++;
              $display("FAIL unexpected_miso_word: got %0h, expected none", w);
            end else begin
              e = exp_miso.pop_front();
              chk("miso_word", 32'(w), 32'(e));
            end
          end
        end
        if (spi_cs) n = 0;
      end
      prev = spi_sclk;
    end
  end

  task automatic send_frame(input int nbits, input int ph, input bit coinc);
    int w;
    tx_data = ft[0];
    spi_cs  = 1'b0;
    repeat (ph + 2) @(negedge clk);
    chk("busy_in_frame", 32'(busy), 32'd1);
    for (int b = 0; b < nbits; b++) begin
      w = b / 8;
      spi_mosi = fw[w][7 - (b % 8)];
      repeat (ph) @(negedge clk);
      if (b % 8 == 7) begin
        exp_q.push_back('{1'b0, fw[w], 32'(cyc + 3)});
        exp_miso.push_back(ft[w]);
        last_rx = fw[w];
      end
      spi_sclk = 1'b1;
      if (b % 8 == 7 && w < 3) tx_data = ft[w + 1];
      if (b == nbits - 1 && coinc) spi_cs = 1'b1;
      repeat (ph) @(negedge clk);
      spi_sclk = 1'b0;
    end
    if (!coinc) begin
      repeat (ph) @(negedge clk);
      spi_cs = 1'b1;
      if (nbits % 8 != 0) exp_q.push_back('{1'b1, 8'h00, 32'(cyc + 3)});
    end
    repeat (ph + 4) @(negedge clk);
    chk("busy_after_frame", 32'(busy), 32'd0);
    chk("rx_data_hold", 32'(rx_data), 32'(last_rx));
  endtask

  task automatic clock_bits(input logic [7:0] v, input int ph, input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = v[7 - i];
      repeat (ph) @(negedge clk);
      spi_sclk = 1'b1;
      repeat (ph) @(negedge clk);
      spi_sclk = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    last_rx  = 8'h00;
    reset_n  = 1'b0;
    spi_cs   = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    tx_data  = 8'h00;
    for (int k = 0; k < 4; k++) begin
      fw[k] = 8'h00;
      ft[k] = 8'h00;
    end
    repeat (3) @(negedge clk);
    chk("reset_rx_data",   32'(rx_data),   32'd0);
    chk("reset_rx_valid",  32'(rx_valid),  32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    chk("reset_miso",      32'(spi_miso),  32'd0);
    chk("reset_busy",      32'(busy),      32'd0);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);

    // Single byte, MISO response 0x3C.
    fw[0] = 8'hA5; ft[0] = 8'h3C;
    send_frame(8, 10, 1'b0);

    // Burst of three words, response changes after the first.
    fw[0] = 8'h01; fw[1] = 8'h0B; fw[2] = 8'hFF;
    ft[0] = 8'h96; ft[1] = 8'h81; ft[2] = 8'h81;
    send_frame(24, 10, 1'b0);

    // Truncated frame, then a clean one.
    fw[0] = 8'hE1; ft[0] = 8'h00;
    send_frame(5, 10, 1'b0);
    fw[0] = 8'h5A; ft[0] = 8'($urandom);
    send_frame(8, 10, 1'b0);

    // Reset in the middle of a frame; the rest of that CS-low period must be ignored.
    tx_data = 8'hE7;
    spi_cs  = 1'b0;
    repeat (12) @(negedge clk);
    clock_bits(8'hA0, 6, 3);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midreset_rx_data", 32'(rx_data), 32'd0);
    chk("midreset_busy",    32'(busy),    32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    last_rx = 8'h00;
    @(negedge clk);
    chk("postreset_miso", 32'(spi_miso), 32'd0);
    chk("postreset_busy", 32'(busy),     32'd0);
    exp_miso.push_back(8'h00);
    clock_bits(8'hFF, 6, 8);
    repeat (10) @(negedge clk);
    chk("unarmed_busy", 32'(busy), 32'd0);
    spi_cs = 1'b1;
    repeat (10) @(negedge clk);
    chk("unarmed_rx_data", 32'(rx_data), 32'd0);
    fw[0] = 8'hC3; ft[0] = 8'($urandom);
    send_frame(8, 6, 1'b0);

    // Last sclk rise and CS rise on the same pin transition.
    fw[0] = 8'h6E; ft[0] = 8'($urandom);
    send_frame(8, 7, 1'b1);

    for (int f = 0; f < 25; f++) begin
      int nb;
      int ph;
      bit co;
      nb = 8 * int'($urandom_range(1, 3));
      co = 1'b0;
      for (int k = 0; k < 4; k++) begin
        fw[k] = 8'($urandom);
        ft[k] = 8'($urandom);
      end
      case ($urandom_range(0, 3))
        0:       nb = nb - int'($urandom_range(1, 7));
        1:       co = 1'b1;
        default: ;
      endcase
      ph = int'($urandom_range(4, 9));
      send_frame(nb, ph, co);
    end

    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && exp_miso.size() == 0) break;
      @(negedge clk);
    end
    chk("leftover_events",     32'(exp_q.size()),    32'd0);
    chk("leftover_miso_words", 32'(exp_miso.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
# spi_slave_rx

SPI mode-0 slave that terminates the 3-wire link driven by the on-board SPI master (`spi_mosi`/`spi_clk`/`spi_cs`). It is used in the loopback/test build to recover transmitted count bytes inside the FPGA. It oversamples the SPI pins with the system clock, deserialises MSB-first words, flags truncated frames, and shifts a response word out on MISO. The block sits between the pin pads and the on-chip consumer; SPI is treated as asynchronous to `clk`.

## Interface
- `DATA_W`, default 8: word length in bits (≥2).
- `SYNC_STAGES`, default 2: synchroniser depth on each SPI input (≥2).

- `clk` in 1: system clock; all logic on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset (asserts immediately, releases on `clk`).
- `spi_sclk` in 1: SPI clock from master, asynchronous.
- `spi_mosi` in 1: serial data from master, asynchronous.
- `spi_cs` in 1: chip select, active low, asynchronous.
- `spi_miso` out 1: serial data to master.
- `tx_data` in DATA_W: response word; sampled at word start.
- `rx_data` out DATA_W: last complete received word; held until next word completes.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `frame_err` out 1: one-cycle pulse when CS deasserts mid-word.
- `busy` out 1: high while in ACTIVE.

## Operation
- Input path: `spi_sclk`, `spi_mosi`, `spi_cs` each pass through SYNC_STAGES flops, plus one history flop for sclk and cs. Reset values: sclk chain 0, mosi chain 0, cs chain 1.
- Edge events are decoded from the last sync stage vs. the history flop: `sck_rise`, `sck_fall`, `cs_fall`, `cs_rise`.
- State machine with states IDLE, ACTIVE, and an `armed` flag:
  - `armed` clears on reset and sets on the first cycle with synchronised cs = 1. A low CS present at reset release is ignored until CS has been seen high.
  - IDLE → ACTIVE on `cs_fall` while armed. On entry: bit_cnt ← 0; tx_shift ← `tx_data`; `spi_miso` ← `tx_data[DATA_W-1]`.
  - ACTIVE → IDLE on `cs_rise`.
- Receive (ACTIVE only):
  - On `sck_rise`, rx_shift ← {rx_shift[DATA_W-2:0], mosi_sync}; bit_cnt increments.
  - When bit_cnt reaches DATA_W on that edge: `rx_data` ← completed word; `rx_valid` pulses; bit_cnt wraps to 0. Back-to-back words under one CS are supported.
- Transmit (ACTIVE only):
  - On `sck_fall` with bit_cnt ≠ 0, shift tx_shift left and drive the new MSB on `spi_miso`.
  - On `sck_fall` with bit_cnt = 0 (a word just completed), reload tx_shift from `tx_data` and drive its MSB.
- `spi_miso` = 0 in IDLE (no tri-state).
- `cs_rise` with bit_cnt ≠ 0: `frame_err` pulses; partial rx_shift is discarded; `rx_data` is unchanged. With bit_cnt = 0, there is no error.
- Simultaneous `sck_rise` and `cs_rise` in one cycle: the rise is processed first. If it completes a word, `rx_valid` pulses and `frame_err` does not.
- sclk edges in IDLE are ignored.
- Reset values: `rx_data` 0, `rx_valid` 0, `frame_err` 0, `spi_miso` 0, `busy` 0, state IDLE, bit_cnt 0.

## Timing
- Pin-to-event latency is SYNC_STAGES+1 `clk` edges. With the default, a pin change is acted on at the 3rd `clk` rising edge after it.
- `rx_valid` is asserted for exactly one cycle, starting 3 edges after the pin rise of the DATA_W-th sclk.
- `frame_err` is asserted for one cycle, starting 3 edges after the CS pin rises.
- `busy` rises 3 edges after the CS pin falls and falls 3 edges after it rises.
- Input constraints on the master:
  - sclk high and low phases ≥ SYNC_STAGES+2 `clk` periods.
  - mosi stable ≥1 `clk` period around each sclk rise.
  - CS high ≥ SYNC_STAGES+2 periods between frames.
- MISO is valid ≤ SYNC_STAGES+2 `clk` after each sclk fall (and after the CS fall for the first bit). The master samples on the next rise.
- `tx_data` must be stable at the `cs_fall` event and at each word-boundary `sck_fall`.

## Test plan
- Single byte: CS low, MOSI 0xA5 MSB-first, sclk 8 cycles at 10 clk/phase, CS high → one `rx_valid` pulse with `rx_data`=0xA5; `frame_err` stays 0; `busy` high only during the frame.
- MISO: `tx_data`=0x3C before CS falls; sample `spi_miso` on each sclk rise → 0,0,1,1,1,1,0,0.
- Burst: one CS, 3 words 0x01, 0x0B, 0xFF; `tx_data` changed to 0x81 after the first word → three `rx_valid` pulses with those values; second and third MISO words = 0x81.
- Truncation: CS high after 5 sclk rises → `frame_err` pulses once, `rx_data` keeps its previous value, no `rx_valid`; the next full frame 0x5A is received correctly.
- Reset mid-frame: assert `reset_n`=0 after 3 bits with CS held low, then release → all outputs 0, no `rx_valid` or `frame_err` for the rest of that CS-low period; after CS goes high and a new 0xC3 frame is sent, `rx_data`=0xC3.
- Coincident edges: 8th sclk rise and CS rise on the same clk-aligned pin transition → `rx_valid` pulses with the correct byte and `frame_err` = 0.
